teclado_matricial: RTL and testbench

- Scans a COLS x ROWS push-button matrix: drives one column strobe at a time and samples the row returns.
- Debounces the first key found and emits a one-cycle key_valid pulse carrying the key's column/row coordinates.
- Input-side counterpart of the LED-matrix column scanner; gives the player a direct (coordColuna, coordLinha) attack entry in place of switches.
- Enabled by the game's ATAQUE state.

---
 rtl/teclado_pkg.sv | 22 ++
 rtl/teclado_prescaler.sv | 34 +++
 rtl/teclado_matricial.sv | 231 +++++++++++++++++++++++
 tb/tb_teclado_matricial.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/teclado_pkg.sv
// Shared definitions for the push-button matrix scanner: FSM state
// encoding, coordinate width and a counter-width helper.
package teclado_pkg;

  localparam int unsigned COORD_W = 3;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Bits needed to hold any value in 0..max_val (at least 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((max_val >> w) != 0) w++;
    return w;
  endfunction

endpackage

// File: rtl/teclado_prescaler.sv
// Scan-tick prescaler: counts 0..SCAN_DIV-1 while enabled, tick on the
// last count, synchronous clear whenever the enable is low.
module teclado_prescaler
  import teclado_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CW = cnt_width(SCAN_DIV - 1);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear when disabled or on wrap, otherwise increment.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || (cnt_q == LAST)) cnt_d = '0;
    else                          cnt_d = cnt_q + CW'(1);
  end

  // Prescaler count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/teclado_matricial.sv
// Push-button matrix scanner: strobes one column at a time (active low),
// samples synchronised row returns on scan ticks, debounces the first key
// found and reports its coordinates with a one-cycle key_valid pulse.
// Optional auto-repeat while held: define TECLADO_REPEAT_EN.
module teclado_matricial
  import teclado_pkg::*;
#(
  parameter int unsigned COLS           = 5,
  parameter int unsigned ROWS           = 7,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 10
`ifdef TECLADO_REPEAT_EN
  , parameter int unsigned REPEAT_TICKS = 250
`endif
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [ROWS-1:0]    row_n,
  output logic [COLS-1:0]    col_n,
  output logic [COORD_W-1:0] coordColuna,
  output logic [COORD_W-1:0] coordLinha,
  output logic               key_valid,
  output logic               key_held
);

  localparam int unsigned DCW = cnt_width(DEBOUNCE_TICKS);
  localparam logic [DCW-1:0]     DB_LAST  = DCW'(DEBOUNCE_TICKS - 1);
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(COLS - 1);

  logic               enable_q;
  logic [ROWS-1:0]    row_meta_q, row_sync_q;
  logic               scan_tick;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] cand_q, cand_d;
  logic [DCW-1:0]     dcnt_q, dcnt_d;
  logic [COORD_W-1:0] coord_col_q, coord_col_d;
  logic [COORD_W-1:0] coord_row_q, coord_row_d;
  logic               valid_q, valid_d;
  logic               held_q, held_d;
  logic [COLS-1:0]    col_n_q, col_n_d;

`ifdef TECLADO_REPEAT_EN
  localparam int unsigned RCW = cnt_width(REPEAT_TICKS - 1);
  localparam logic [RCW-1:0] REP_LAST = RCW'(REPEAT_TICKS - 1);
  logic [RCW-1:0]     rep_q, rep_d;
`endif

  logic               any_low;
  logic               cand_low;
  logic               first_found;
  logic [COORD_W-1:0] first_low;
  logic [COORD_W-1:0] col_next;

  // Prescaler runs from the registered enable so that the column strobe,
  // which appears one cycle after enable rises, still gets a full dwell.
  teclado_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .en_i   (enable_q),
    .tick_o (scan_tick)
  );

  // Two-flop synchroniser for the asynchronous row returns; enable delay.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      enable_q   <= 1'b0;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
      enable_q   <= enable;
    end
  end

  // Lowest-index low row in the current sample; row-state helpers.
  always_comb begin
    first_low   = '0;
    first_found = 1'b0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (!row_sync_q[i] && !first_found) begin
        first_low   = COORD_W'(i);
        first_found = 1'b1;
      end
    end
    any_low  = ~&row_sync_q;
    cand_low = ~row_sync_q[cand_q];
    col_next = (col_q == COL_LAST) ? '0 : col_q + COORD_W'(1);
  end

  // Scan/debounce FSM next-state and outputs.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cand_d      = cand_q;
    dcnt_d      = dcnt_q;
    coord_col_d = coord_col_q;
    coord_row_d = coord_row_q;
    valid_d     = 1'b0;
    held_d      = held_q;
`ifdef TECLADO_REPEAT_EN
    rep_d       = rep_q;
`endif
    if (!enable) begin
      state_d = SCAN;
      col_d   = '0;
      dcnt_d  = '0;
      held_d  = 1'b0;
`ifdef TECLADO_REPEAT_EN
      rep_d   = '0;
`endif
    end else if (scan_tick) begin
      case (state_q)
        SCAN: begin
          if (any_low) begin
            cand_d  = first_low;
            dcnt_d  = DCW'(1);
            state_d = DEBOUNCE;
          end else begin
            col_d = col_next;
          end
        end
        DEBOUNCE: begin
          if (cand_low) begin
            if (dcnt_q == DB_LAST) begin
              coord_col_d = col_q;
              coord_row_d = cand_q;
              valid_d     = 1'b1;
              held_d      = 1'b1;
              dcnt_d      = '0;
              state_d     = PRESSED;
`ifdef TECLADO_REPEAT_EN
              rep_d       = '0;
`endif
            end else begin
              dcnt_d = dcnt_q + DCW'(1);
            end
          end else begin
            dcnt_d  = '0;
            col_d   = col_next;
            state_d = SCAN;
          end
        end
        PRESSED: begin
          if (!cand_low) begin
            dcnt_d  = DCW'(1);
            state_d = RELEASE;
`ifdef TECLADO_REPEAT_EN
            rep_d   = '0;
          end else if (rep_q == REP_LAST) begin
            valid_d = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d   = rep_q + RCW'(1);
`endif
          end
        end
        RELEASE: begin
          if (cand_low) begin
            dcnt_d  = '0;
            state_d = PRESSED;
`ifdef TECLADO_REPEAT_EN
            rep_d   = '0;
`endif
          end else if (dcnt_q == DB_LAST) begin
            dcnt_d  = '0;
            held_d  = 1'b0;
            col_d   = col_next;
            state_d = SCAN;
          end else begin
            dcnt_d = dcnt_q + DCW'(1);
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // Column strobe follows the next column index so it lines up with col_q.
  always_comb begin
    col_n_d = '1;
    if (enable) begin
      for (int unsigned i = 0; i < COLS; i++) begin
        col_n_d[i] = (col_d != COORD_W'(i));
      end
    end
  end

  // FSM and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SCAN;
      col_q       <= '0;
      cand_q      <= '0;
      dcnt_q      <= '0;
      coord_col_q <= '0;
      coord_row_q <= '0;
      valid_q     <= 1'b0;
      held_q      <= 1'b0;
      col_n_q     <= '1;
`ifdef TECLADO_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cand_q      <= cand_d;
      dcnt_q      <= dcnt_d;
      coord_col_q <= coord_col_d;
      coord_row_q <= coord_row_d;
      valid_q     <= valid_d;
      held_q      <= held_d;
      col_n_q     <= col_n_d;
`ifdef TECLADO_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign col_n       = col_n_q;
  assign coordColuna = coord_col_q;
  assign coordLinha  = coord_row_q;
  assign key_valid   = valid_q;
  assign key_held    = held_q;

endmodule

// File: tb/tb_teclado_matricial.sv
// Self-checking bench for teclado_matricial (COLS=5, ROWS=7, SCAN_DIV=4,
// DEBOUNCE_TICKS=3, REPEAT_TICKS=5 when TECLADO_REPEAT_EN is defined).
// A key-matrix model pulls row lines low for pressed keys in the strobed column.
module tb_teclado_matricial;

  localparam int COLS = 5;
  localparam int ROWS = 7;

`ifdef TECLADO_REPEAT_EN
  localparam int EXP_EXTRA = 2;
`else
  localparam int EXP_EXTRA = 0;
`endif

  logic            clock;
  logic            reset_n;
  logic            enable;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_n;
  logic [2:0]      coordColuna;
  logic [2:0]      coordLinha;
  logic            key_valid;
  logic            key_held;

  logic [ROWS-1:0] keys [COLS];

  int n_pass  = 0;
  int n_total = 0;

  teclado_matricial #(
    .COLS           (5),
    .ROWS           (7),
    .SCAN_DIV       (4),
    .DEBOUNCE_TICKS (3)
`ifdef TECLADO_REPEAT_EN
    , .REPEAT_TICKS (5)
`endif
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .row_n       (row_n),
    .col_n       (col_n),
    .coordColuna (coordColuna),
    .coordLinha  (coordLinha),
    .key_valid   (key_valid),
    .key_held    (key_held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Passive matrix: a pressed key shorts its row to the strobed column.
  always_comb begin
    row_n = '1;
    for (int c = 0; c < COLS; c++) begin
      if (!col_n[c]) row_n = row_n & ~keys[c];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if (key_valid) begin
        ok = 1'b1;
        cyc = i;
        break;
      end
    end
  endtask

  // Waits for key_held to drop; also counts key_valid pulses meanwhile.
  task automatic wait_held_low(input int max_cyc, output bit ok, output int pulses);
    ok = 1'b0;
    pulses = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if (key_valid) pulses++;
      if (!key_held) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_col(input logic [COLS-1:0] target, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if (col_n == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (key_valid) pulses++;
    end
  endtask

  typedef struct {
    int         col;
    int         row;
    logic [2:0] exp_col;
    logic [2:0] exp_row;
    logic [4:0] exp_next;
  } press_vec_t;

  press_vec_t vecs [4];

  initial begin
    bit         ok;
    int         cyc;
    int         pulses;
    logic [4:0] exp_strobe;
    logic [4:0] seen;

    vecs[0] = '{col: 2, row: 4, exp_col: 3'd2, exp_row: 3'd4, exp_next: 5'b10111};
    vecs[1] = '{col: 0, row: 0, exp_col: 3'd0, exp_row: 3'd0, exp_next: 5'b11101};
    vecs[2] = '{col: 4, row: 6, exp_col: 3'd4, exp_row: 3'd6, exp_next: 5'b11110};
    vecs[3] = '{col: 3, row: 1, exp_col: 3'd3, exp_row: 3'd1, exp_next: 5'b01111};

    for (int c = 0; c < COLS; c++) keys[c] = '0;
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_col_n", col_n, 5'b11111);
    check("rst_coordColuna", coordColuna, 3'd0);
    check("rst_coordLinha", coordLinha, 3'd0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_held", key_held, 1'b0);

    // Idle scan: each column held for 4 cycles, wrapping after column 4
    reset_n = 1'b1;
    enable  = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      exp_strobe = ~(5'b00001 << ((i / 4) % 5));
      check("scan_strobe", col_n, exp_strobe);
      if (key_valid) pulses++;
    end
    check("scan_no_valid", pulses, 0);

    // Single-key presses from the vector table
    for (int v = 0; v < 4; v++) begin
      keys[vecs[v].col][vecs[v].row] = 1'b1;
      wait_valid(200, ok, cyc);
      check("tbl_valid_seen", ok, 1'b1);
      check("tbl_coordColuna", coordColuna, vecs[v].exp_col);
      check("tbl_coordLinha", coordLinha, vecs[v].exp_row);
      check("tbl_key_held", key_held, 1'b1);
      @(negedge clock);
      check("tbl_pulse_width", key_valid, 1'b0);
      keys[vecs[v].col][vecs[v].row] = 1'b0;
      wait_held_low(100, ok, pulses);
      check("tbl_release_seen", ok, 1'b1);
      check("tbl_release_pulses", pulses, 0);
      check("tbl_next_strobe", col_n, vecs[v].exp_next);
      check("tbl_coords_kept", {coordColuna, coordLinha}, {vecs[v].exp_col, vecs[v].exp_row});
    end

    // Bounce: key low for a single tick only
    wait_col(5'b11011, 100, ok);
    check("bounce_reach_col2", ok, 1'b1);
    keys[2][4] = 1'b1;
    repeat (4) @(negedge clock);
    keys[2][4] = 1'b0;
    pulses = 0;
    seen = 5'b11011;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (key_valid) pulses++;
      if (col_n != 5'b11011) begin
        seen = col_n;
        break;
      end
    end
    check("bounce_next_strobe", seen, 5'b10111);
    check("bounce_no_valid", pulses, 0);
    check("bounce_no_held", key_held, 1'b0);

    // Multiple keys: rows 1 and 5 in column 0, row 2 in column 3
    wait_col(5'b11110, 100, ok);
    check("multi_reach_col0", ok, 1'b1);
    keys[0][1] = 1'b1;
    keys[0][5] = 1'b1;
    keys[3][2] = 1'b1;
    wait_valid(100, ok, cyc);
    check("multi_valid_seen", ok, 1'b1);
    check("multi_coordColuna", coordColuna, 3'd0);
    check("multi_coordLinha", coordLinha, 3'd1);
    count_pulses(12, pulses);
    check("multi_col3_ignored", pulses, 0);
    check("multi_still_held", key_held, 1'b1);
    keys[0][1] = 1'b0;
    keys[0][5] = 1'b0;
    wait_held_low(100, ok, pulses);
    check("multi_release_seen", ok, 1'b1);
    wait_valid(100, ok, cyc);
    check("multi_second_valid", ok, 1'b1);
    check("multi_second_col", coordColuna, 3'd3);
    check("multi_second_row", coordLinha, 3'd2);
    keys[3][2] = 1'b0;
    wait_held_low(100, ok, pulses);
    check("multi_second_release", ok, 1'b1);

    // Enable dropped during PRESSED, then re-enabled with the key held
    keys[2][4] = 1'b1;
    wait_valid(200, ok, cyc);
    check("en_valid_seen", ok, 1'b1);
    repeat (2) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check("en_off_col_n", col_n, 5'b11111);
    check("en_off_key_held", key_held, 1'b0);
    check("en_off_key_valid", key_valid, 1'b0);
    check("en_off_coords", {coordColuna, coordLinha}, {3'd2, 3'd4});
    repeat (5) @(negedge clock);
    check("en_off_idle_col_n", col_n, 5'b11111);
    enable = 1'b1;
    // col 0 and col 1 dwell 4 cycles each, then 3 ticks in col 2
    wait_valid(60, ok, cyc);
    check("en_reacquire_seen", ok, 1'b1);
    check("en_reacquire_cycle", cyc, 20);
    check("en_reacquire_coords", {coordColuna, coordLinha}, {3'd2, 3'd4});
    keys[2][4] = 1'b0;
    wait_held_low(100, ok, pulses);
    check("en_release_seen", ok, 1'b1);

    // Long hold: 13 ticks after acceptance (auto-repeat when enabled)
    keys[1][3] = 1'b1;
    wait_valid(200, ok, cyc);
    check("hold_valid_seen", ok, 1'b1);
    count_pulses(52, pulses);
    check("hold_extra_pulses", pulses, EXP_EXTRA);
    check("hold_coords", {coordColuna, coordLinha}, {3'd1, 3'd3});
    keys[1][3] = 1'b0;
    wait_held_low(100, ok, pulses);
    check("hold_release_seen", ok, 1'b1);
    check("hold_release_pulses", pulses, 0);

    // Reset asserted mid-press
    keys[4][0] = 1'b1;
    wait_valid(200, ok, cyc);
    check("rstmid_valid_seen", ok, 1'b1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rstmid_col_n", col_n, 5'b11111);
    check("rstmid_key_held", key_held, 1'b0);
    check("rstmid_coords", {coordColuna, coordLinha}, 6'd0);
    check("rstmid_key_valid", key_valid, 1'b0);
    keys[4][0] = 1'b0;
    count_pulses(3, pulses);
    check("rstmid_during_pulses", pulses, 0);
    reset_n = 1'b1;
    count_pulses(40, pulses);
    check("rstmid_after_pulses", pulses, 0);
    check("rstmid_after_held", key_held, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
